// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch unit.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Redirect, ROM and decoder-side signals of the fetch unit.
interface fetch_unit_if #(
  parameter int BUS_WIDTH = 16
) ();
  logic                 redirect;
  logic [BUS_WIDTH-1:0] redirect_addr;
  logic                 rom_req;
  logic [BUS_WIDTH-1:0] rom_addr;
  logic                 rom_ack;
  logic [BUS_WIDTH-1:0] rom_data;
  logic [BUS_WIDTH-1:0] instr;
  logic [BUS_WIDTH-1:0] instr_pc;
  logic                 instr_valid;
  logic                 instr_ready;

  modport master (
    input  redirect, redirect_addr, rom_ack, rom_data, instr_ready,
    output rom_req, rom_addr, instr, instr_pc, instr_valid
  );

  modport slave (
    output redirect, redirect_addr, rom_ack, rom_data, instr_ready,
    input  rom_req, rom_addr, instr, instr_pc, instr_valid
  );
endinterface

// File: rtl/inc.sv
// Modulo-2^WIDTH incrementer.
module inc #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);
  assign y = a + WIDTH'(1);
endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction prefetcher: one outstanding ROM read, small in-order buffer.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int BUS_WIDTH = 16,
  parameter int DEPTH     = 2
) (
  input logic          clock,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t state, state_nxt;
  logic [BUS_WIDTH-1:0] fp, fp_nxt, fp_inc, addr_q, addr_nxt;
  logic                 req_q, req_nxt, push, flush, pop, valid;
  logic [AW-1:0]        head, tail;
  logic [CW-1:0]        count;
  logic [BUS_WIDTH-1:0] mem_instr [DEPTH];
  logic [BUS_WIDTH-1:0] mem_pc    [DEPTH];

  inc #(.WIDTH(BUS_WIDTH)) u_inc (.a(fp), .y(fp_inc));

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fp_nxt    = fp;
    req_nxt   = req_q;
    addr_nxt  = addr_q;
    push      = 1'b0;
    flush     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.redirect) begin
          flush  = 1'b1;
          fp_nxt = bus.redirect_addr;
        end else if (count < FULL) begin
          req_nxt   = 1'b1;
          addr_nxt  = fp;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.redirect) begin
          flush  = 1'b1;
          fp_nxt = bus.redirect_addr;
          // an unacked read cannot be withdrawn; its data is swallowed in DISCARD
          if (bus.rom_ack) begin
            req_nxt   = 1'b0;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DISCARD;
          end
        end else if (bus.rom_ack) begin
          push      = 1'b1;
          fp_nxt    = fp_inc;
          req_nxt   = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      S_DISCARD: begin
        if (bus.redirect) begin
          flush  = 1'b1;
          fp_nxt = bus.redirect_addr;
        end
        if (bus.rom_ack) begin
          req_nxt   = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign valid = (count != '0);
  assign pop   = valid & bus.instr_ready & ~bus.redirect;

  always_ff @(posedge clock) begin
    if (!reset) begin
      fp     <= '0;
      req_q  <= 1'b0;
      addr_q <= '0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else begin
      fp     <= fp_nxt;
      req_q  <= req_nxt;
      addr_q <= addr_nxt;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + AW'(1);
        if (pop)  head <= head + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // storage needs no reset: outputs are masked while the buffer is empty
  always_ff @(posedge clock) begin
    if (reset && push) begin
      mem_instr[tail] <= bus.rom_data;
      mem_pc[tail]    <= fp;
    end
  end

  assign bus.rom_req     = req_q;
  assign bus.rom_addr    = addr_q;
  assign bus.instr_valid = valid;
  assign bus.instr       = valid ? mem_instr[head] : '0;
  assign bus.instr_pc    = valid ? mem_pc[head]    : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: randomized ROM latency/redirects against a stream-level reference model.
module tb_fetch_unit;
  localparam int BW    = 16;
  localparam int DEPTH = 2;

  logic clock, reset;
  fetch_unit_if #(.BUS_WIDTH(BW)) bus ();

  fetch_unit #(.BUS_WIDTH(BW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .bus(bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_asrt = 0, n_fail = 0;
  // model: expected next fetch address, expected head pc, buffer occupancy
  logic [BW-1:0] exp_fetch, exp_pc, req_addr, salt, pc0, pc1;
  int occ, epoch, req_epoch, age, cur_lat, lat_mode;
  int n_valid, n_pop, n_rise, n_since;
  bit prev_req, bad_data, spurious, found;

  function automatic logic [BW-1:0] rom_val(input logic [BW-1:0] a);
    return (a * 16'h9E37) ^ salt ^ {a[7:0], a[15:8]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_addr = BW'($urandom);
    bus.rom_ack = 1'b1;
    bus.rom_data = BW'($urandom);
    bus.instr_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_rom_req", bus.rom_req, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_instr_pc", bus.instr_pc, 0);
    occ = 0; exp_fetch = '0; exp_pc = '0; epoch++;
    prev_req = 1'b0; age = 0; bad_data = 1'b0; n_since = 0;
    reset = 1'b1; bus.redirect = 1'b0; bus.rom_ack = 1'b0;
    spurious = 1'b1;
  endtask

  // called at posedge+1: check outputs, drive inputs, advance model, step one clock
  task automatic tick(input bit rdy, input bit redir, input logic [BW-1:0] raddr);
    bit ack, pop;
    if (bus.rom_req && !prev_req) begin
      n_rise++;
      chk("req_addr", bus.rom_addr, exp_fetch);
      chk("req_room", occ < DEPTH, 1);
      req_epoch = epoch; req_addr = bus.rom_addr; age = 0;
      cur_lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
    end else if (bus.rom_req) begin
      chk("addr_stable", bus.rom_addr, req_addr);
    end
    chk("valid", bus.instr_valid, occ != 0);
    if (bus.instr_valid) begin
      n_valid++;
      chk("instr_pc", bus.instr_pc, exp_pc);
      chk("instr", bus.instr, rom_val(exp_pc));
    end else begin
      chk("idle_instr", bus.instr, 0);
      chk("idle_pc", bus.instr_pc, 0);
    end
    ack = bus.rom_req && (age >= cur_lat);
    bus.rom_data = ack ? (bad_data ? 16'hDEAD : rom_val(bus.rom_addr)) : BW'($urandom);
    if (spurious && !bus.rom_req) ack = 1'b1;
    spurious = 1'b0;
    bus.rom_ack = ack;
    bus.instr_ready = rdy;
    bus.redirect = redir;
    bus.redirect_addr = redir ? raddr : BW'($urandom);
    pop = bus.instr_valid && rdy && !redir;
    if (pop) begin
      if (n_since == 0) pc0 = bus.instr_pc;
      if (n_since == 1) pc1 = bus.instr_pc;
      n_since++; n_pop++;
    end
    if (redir) begin
      occ = 0; exp_fetch = raddr; exp_pc = raddr; epoch++;
    end else begin
      if (pop) begin occ--; exp_pc++; end
      if (ack && bus.rom_req && req_epoch == epoch) begin occ++; exp_fetch++; end
    end
    if (ack && bus.rom_req) bad_data = 1'b0;
    if (bus.rom_req && !ack) age++;
    prev_req = bus.rom_req;
    @(posedge clock);
    #1;
  endtask

  initial begin
    salt = BW'($urandom);
    epoch = 0; lat_mode = 0; n_rise = 0;
    do_reset();

    // back-to-back fetch with single-cycle ROM
    tick(1, 0, 0); tick(1, 0, 0);
    n_valid = 0; n_pop = 0;
    repeat (8) tick(1, 0, 0);
    chk("b2b_valid_rate", n_valid, 4);
    chk("b2b_pops", n_pop, 4);

    // stalled decoder fills exactly DEPTH entries
    tick(1, 1, 16'h0010);
    n_rise = 0;
    repeat (20) tick(0, 0, 0);
    chk("stall_rises", n_rise, DEPTH);
    chk("stall_req_low", bus.rom_req, 0);
    chk("stall_valid", bus.instr_valid, 1);
    n_pop = 0;
    repeat (10) tick(1, 0, 0);
    chk("stall_drain", n_pop >= 3, 1);

    // redirect during an outstanding read at fp=5; stale 0xDEAD must vanish
    do_reset();
    lat_mode = 3; found = 0;
    for (int i = 0; i < 80; i++) begin
      if (bus.rom_req && bus.rom_addr == 16'd5) begin found = 1; break; end
      tick(1, 0, 0);
    end
    chk("reach_fp5", found, 1);
    bad_data = 1'b1;
    n_since = 0;
    tick(1, 1, 16'h0100);
    repeat (14) tick(1, 0, 0);
    chk("redir_first_pc", pc0, 16'h0100);
    chk("redir_progress", n_since >= 1, 1);

    // redirect coinciding with a pop
    lat_mode = -1; found = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.instr_valid) begin found = 1; break; end
      tick(1, 0, 0);
    end
    chk("pop_ready", found, 1);
    tick(1, 1, 16'h0200);
    chk("redir_pop_empty", bus.instr_valid, 0);
    repeat (6) tick(1, 0, 0);

    // address wrap
    n_since = 0;
    tick(1, 1, 16'hFFFF);
    repeat (24) tick(1, 0, 0);
    chk("wrap_pc0", pc0, 16'hFFFF);
    chk("wrap_pc1", pc1, 16'h0000);

    // reset while a read is outstanding
    lat_mode = 3; found = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.rom_req) begin found = 1; break; end
      tick(1, 0, 0);
    end
    chk("wait_reached", found, 1);
    do_reset();
    lat_mode = 0;
    repeat (8) tick(1, 0, 0);
    chk("restart_pc", pc0, 16'h0000);

    // random traffic
    lat_mode = -1;
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, BW'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
